// File: rtl/matrix_stream_reader_pkg.sv
// Shared types for the matrix block reader.
// Header layout, reader states and read-pipeline tags.
package matrix_pkg;

  localparam int unsigned META_WORDS = 3;
  localparam int unsigned ROWS_MSB   = 31;
  localparam int unsigned COLS_MSB   = 23;

  typedef enum logic [2:0] {
    S_IDLE,
    S_META,
    S_META_WAIT,
    S_CHECK,
    S_STREAM,
    S_DRAIN,
    S_FIN
  } rd_state_e;

  typedef struct packed {
    logic vld;
    logic meta;
    logic row_last;
    logic last;
  } rd_tag_t;

endpackage

// File: rtl/matrix_stream_reader_fifo.sv
// Synchronous output FIFO with occupancy count and flush.
// Push into a full FIFO is accepted only together with a pop.
module stream_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != (PW+1)'(DEPTH)) || do_pop);
  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/matrix_stream_reader.sv
// Reads one matrix block (header + elements) from BRAM and streams
// the elements in row- or column-major order through an output FIFO.
module matrix_stream_reader
  import matrix_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS   = 8,
  parameter int unsigned BLOCK_SIZE   = 1152,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(NUM_BLOCKS)-1:0] matrix_id,
  input  logic                          col_major,
  input  logic                          abort,
  output logic                          ready,
  output logic                          done,
  output logic                          err,
  output logic [7:0]                    rows,
  output logic [7:0]                    cols,
  output logic [63:0]                   matrix_name,
  output logic                          meta_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_row_last,
  output logic                          m_last,
  output logic                          bram_en,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  input  logic [DATA_WIDTH-1:0]         bram_dout
);

  localparam int unsigned AW  = ADDR_WIDTH;
  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

  rd_state_e            state_q;
  logic                 ready_q, done_q, err_q, meta_valid_q;
  logic                 col_major_q;
  logic [7:0]           rows_q, cols_q, inner_q;
  logic [63:0]          name_q;
  logic [AW-1:0]        base_q, addr_q, cur_q, col_q;
  logic [1:0]           meta_k_q, meta_rx_q;
  logic [15:0]          issued_q, total_q;
  rd_tag_t              iss_q;
  rd_tag_t              sr_q [READ_LATENCY];

  rd_tag_t              ret;
  logic                 busy, abort_act, push, pop, issue;
  logic                 hdr_bad, inner_end, is_last, fifo_empty;
  logic [7:0]           inner_len;
  logic [15:0]          total_d, in_flight, occ;
  logic [FCW-1:0]       fifo_cnt;
  logic [DATA_WIDTH+1:0] fifo_out;

  assign ret       = sr_q[READ_LATENCY-1];
  assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign abort_act = abort && busy;
  assign push      = ret.vld && !ret.meta && !abort_act;
  assign pop       = !fifo_empty && m_ready;
  assign total_d   = 16'(rows_q) * 16'(cols_q);
  assign hdr_bad   = (rows_q == '0) || (cols_q == '0) ||
                     (total_d > 16'(BLOCK_SIZE - META_WORDS));
  assign inner_len = col_major_q ? rows_q : cols_q;
  assign inner_end = (inner_q == inner_len - 8'd1);
  assign is_last   = (issued_q == total_q - 16'd1);

  // Credit: everything issued but not yet popped must fit the FIFO.
  always_comb begin
    in_flight = '0;
    if (iss_q.vld && !iss_q.meta) in_flight = in_flight + 16'd1;
    for (int i = 0; i < READ_LATENCY; i++)
      if (sr_q[i].vld && !sr_q[i].meta) in_flight = in_flight + 16'd1;
  end

  assign occ   = in_flight + 16'(fifo_cnt) - 16'(pop);
  assign issue = (state_q == S_STREAM) && (issued_q != total_q) &&
                 (occ < 16'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      meta_valid_q <= 1'b0;
      col_major_q  <= 1'b0;
      rows_q       <= '0;
      cols_q       <= '0;
      name_q       <= '0;
      base_q       <= '0;
      addr_q       <= '0;
      cur_q        <= '0;
      col_q        <= '0;
      inner_q      <= '0;
      meta_k_q     <= '0;
      meta_rx_q    <= '0;
      issued_q     <= '0;
      total_q      <= '0;
      iss_q        <= '0;
      for (int i = 0; i < READ_LATENCY; i++) sr_q[i] <= '0;
    end else begin
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      meta_valid_q <= 1'b0;
      iss_q        <= '0;
      sr_q[0]      <= iss_q;
      for (int i = 1; i < READ_LATENCY; i++) sr_q[i] <= sr_q[i-1];

      if (ret.vld && ret.meta && !abort_act) begin
        meta_rx_q <= meta_rx_q + 2'd1;
        unique case (meta_rx_q)
          2'd0: begin
            rows_q <= bram_dout[ROWS_MSB -: 8];
            cols_q <= bram_dout[COLS_MSB -: 8];
          end
          2'd1: name_q[31:0]  <= bram_dout[31:0];
          2'd2: name_q[63:32] <= bram_dout[31:0];
          default: ;
        endcase
      end

      unique case (state_q)
        S_IDLE: if (start) begin
          base_q      <= AW'(matrix_id) * AW'(BLOCK_SIZE);
          col_major_q <= col_major;
          meta_k_q    <= '0;
          meta_rx_q   <= '0;
          ready_q     <= 1'b0;
          state_q     <= S_META;
        end
        S_META: begin
          iss_q    <= '{vld: 1'b1, meta: 1'b1, row_last: 1'b0, last: 1'b0};
          addr_q   <= base_q + AW'(meta_k_q);
          meta_k_q <= meta_k_q + 2'd1;
          if (meta_k_q == 2'd2) state_q <= S_META_WAIT;
        end
        S_META_WAIT:
          if (ret.vld && ret.meta && meta_rx_q == 2'd2) begin
            meta_valid_q <= 1'b1;
            state_q      <= S_CHECK;
          end
        S_CHECK: begin
          if (hdr_bad) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_FIN;
          end else begin
            total_q  <= total_d;
            issued_q <= '0;
            inner_q  <= '0;
            cur_q    <= base_q + AW'(META_WORDS);
            col_q    <= base_q + AW'(META_WORDS);
            state_q  <= S_STREAM;
          end
        end
        S_STREAM: if (issue) begin
          iss_q    <= '{vld: 1'b1, meta: 1'b0,
                        row_last: inner_end, last: is_last};
          addr_q   <= cur_q;
          issued_q <= issued_q + 16'd1;
          if (inner_end) begin
            inner_q <= '0;
            if (col_major_q) begin
              cur_q <= col_q + AW'(1);
              col_q <= col_q + AW'(1);
            end else begin
              cur_q <= cur_q + AW'(1);
            end
          end else begin
            inner_q <= inner_q + 8'd1;
            cur_q   <= cur_q + (col_major_q ? AW'(cols_q) : AW'(1));
          end
          if (is_last) state_q <= S_DRAIN;
        end
        S_DRAIN: if (fifo_empty && in_flight == '0) begin
          done_q  <= 1'b1;
          state_q <= S_FIN;
        end
        S_FIN: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (abort_act) begin
        iss_q        <= '0;
        meta_valid_q <= 1'b0;
        done_q       <= 1'b1;
        err_q        <= 1'b0;
        state_q      <= S_FIN;
        for (int i = 0; i < READ_LATENCY; i++) sr_q[i] <= '0;
      end
    end
  end

  stream_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (abort_act),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({bram_dout, ret.row_last, ret.last}),
    .data_o  (fifo_out),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign ready       = ready_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rows        = rows_q;
  assign cols        = cols_q;
  assign matrix_name = name_q;
  assign meta_valid  = meta_valid_q;
  assign m_valid     = !fifo_empty;
  assign m_data      = fifo_out[DATA_WIDTH+1:2];
  assign m_row_last  = fifo_out[1];
  assign m_last      = fifo_out[0];
  assign bram_en     = iss_q.vld;
  assign bram_addr   = addr_q;

endmodule

// File: tb/tb_matrix_stream_reader.sv
// Directed bench for matrix_stream_reader: a latency-1 and a
// latency-3 instance share one BRAM image; sel picks the active one.
module tb_matrix_stream_reader;

  localparam int BS = 1152;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, col_major = 1'b0, abort = 1'b0;
  logic        m_ready = 1'b1, sel = 1'b0;
  logic [2:0]  matrix_id = '0;
  logic [31:0] mem [16384];

  logic        ready1, done1, err1, mv1, meta1, rl1, ml1, en1;
  logic        ready3, done3, err3, mv3, meta3, rl3, ml3, en3;
  logic [7:0]  rows1, cols1, rows3, cols3;
  logic [63:0] name1, name3;
  logic [31:0] md1, md3, dout1, dout3, p3a, p3b;
  logic [13:0] addr1, addr3;

  logic        ready, done, err, m_valid, meta_valid;
  logic        m_row_last, m_last, bram_en;
  logic [7:0]  rows, cols;
  logic [63:0] matrix_name;
  logic [31:0] m_data;
  logic [13:0] bram_addr;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) dout1 <= mem[addr1];
  always @(posedge clk) begin
    p3a   <= mem[addr3];
    p3b   <= p3a;
    dout3 <= p3b;
  end

  matrix_stream_reader #(.READ_LATENCY(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .start(start & ~sel),
    .matrix_id(matrix_id), .col_major(col_major),
    .abort(abort & ~sel), .ready(ready1), .done(done1), .err(err1),
    .rows(rows1), .cols(cols1), .matrix_name(name1),
    .meta_valid(meta1), .m_data(md1), .m_valid(mv1),
    .m_ready(m_ready), .m_row_last(rl1), .m_last(ml1),
    .bram_en(en1), .bram_addr(addr1), .bram_dout(dout1)
  );

  matrix_stream_reader #(.READ_LATENCY(3), .FIFO_DEPTH(4)) u_dut3 (
    .clk(clk), .rst(rst), .start(start & sel),
    .matrix_id(matrix_id), .col_major(col_major),
    .abort(abort & sel), .ready(ready3), .done(done3), .err(err3),
    .rows(rows3), .cols(cols3), .matrix_name(name3),
    .meta_valid(meta3), .m_data(md3), .m_valid(mv3),
    .m_ready(m_ready), .m_row_last(rl3), .m_last(ml3),
    .bram_en(en3), .bram_addr(addr3), .bram_dout(dout3)
  );

  assign ready       = sel ? ready3 : ready1;
  assign done        = sel ? done3  : done1;
  assign err         = sel ? err3   : err1;
  assign rows        = sel ? rows3  : rows1;
  assign cols        = sel ? cols3  : cols1;
  assign matrix_name = sel ? name3  : name1;
  assign meta_valid  = sel ? meta3  : meta1;
  assign m_data      = sel ? md3    : md1;
  assign m_valid     = sel ? mv3    : mv1;
  assign m_row_last  = sel ? rl3    : rl1;
  assign m_last      = sel ? ml3    : ml1;
  assign bram_en     = sel ? en3    : en1;
  assign bram_addr   = sel ? addr3  : addr1;

  function automatic logic [31:0] dat(input int a);
    return 32'hD000_0000 | 32'(a);
  endfunction

  function automatic logic [63:0] nm(input int b);
    return {32'h4D41_5400 + 32'(b), 32'h4E41_4D30 + 32'(b)};
  endfunction

  function automatic int exp_addr(input int id, input bit cm,
                                  input int nr, input int nc,
                                  input int k);
    int r, c;
    if (cm) begin r = k % nr; c = k / nr; end
    else    begin r = k / nc; c = k % nc; end
    return id * BS + 3 + r * nc + c;
  endfunction

  task automatic set_hdr(input int b, input int r, input int c);
    logic [7:0] r8, c8;
    logic [63:0] n;
    r8 = r[7:0];
    c8 = c[7:0];
    n  = nm(b);
    mem[b*BS]     = {r8, c8, 16'h0000};
    mem[b*BS + 1] = n[31:0];
    mem[b*BS + 2] = n[63:32];
  endtask

  task automatic read_matrix(input int id, input bit cm, input bit rnd,
                             input int er, input int ec, input bit eerr,
                             input int abort_at);
    int n, k, first, lastc, vcnt, a;
    bit seen, fin, rl, ls;
    logic [33:0] expv;
    n = eerr ? 0 : er * ec;
    k = 0; first = -1; lastc = -1; vcnt = 0;
    seen = 0; fin = 0;
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    assert (ready === 1'b1) else begin
      errs++; $error("FAIL ready_pre: got %b want 1", ready);
    end
    start = 1'b1; matrix_id = 3'(id); col_major = cm;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (meta_valid === 1'b1) seen = 1;
      else @(negedge clk);
    end
    checks++;
    assert (seen === 1'b1) else begin
      errs++; $error("FAIL meta_seen: got %b want 1", seen);
    end
    checks++;
    assert (rows === er[7:0] && cols === ec[7:0]) else begin
      errs++; $error("FAIL meta_dims: got %0dx%0d want %0dx%0d",
                     rows, cols, er, ec);
    end
    checks++;
    assert (matrix_name === nm(id)) else begin
      errs++; $error("FAIL meta_name: got %h want %h",
                     matrix_name, nm(id));
    end
    for (int c = 0; c < n * 8 + 60 && !fin; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        fin = 1;
        checks++;
        assert (err === eerr) else begin
          errs++; $error("FAIL done_err: got %b want %b", err, eerr);
        end
      end else begin
        if (m_valid === 1'b1) begin
          a  = exp_addr(id, cm, er, ec, k);
          rl = cm ? (k % er == er - 1) : (k % ec == ec - 1);
          ls = (k == n - 1);
          expv = {dat(a), rl, ls};
          if (first < 0) first = c;
          lastc = c;
          vcnt++;
          checks++;
          assert (k < n && {m_data, m_row_last, m_last} === expv)
          else begin
            errs++;
            $error("FAIL elem%0d: got %h/%b/%b want %h/%b/%b", k,
                   m_data, m_row_last, m_last, dat(a), rl, ls);
          end
        end
        if (abort_at >= 0 && k == abort_at) begin
          m_ready = 1'b0;
          abort   = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          fin   = 1;
          checks++;
          assert (m_valid === 1'b0 && done === 1'b1 && err === 1'b0)
          else begin
            errs++; $error("FAIL abort: got v%b d%b e%b want v0 d1 e0",
                           m_valid, done, err);
          end
        end else begin
          m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          if (m_valid === 1'b1 && m_ready) k++;
        end
      end
    end
    checks++;
    assert (fin === 1'b1) else begin
      errs++; $error("FAIL done_seen: got %b want 1", fin);
    end
    if (abort_at < 0) begin
      checks++;
      assert (k === n) else begin
        errs++; $error("FAIL elem_count: got %0d want %0d", k, n);
      end
    end
    if (!rnd && abort_at < 0 && n > 0) begin
      checks++;
      assert (vcnt === n && lastc - first + 1 === n) else begin
        errs++; $error("FAIL rate: got %0d in %0d cyc want %0d",
                       vcnt, lastc - first + 1, n);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    assert (ready === 1'b1) else begin
      errs++; $error("FAIL ready_post: got %b want 1", ready);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = dat(i);
    set_hdr(1, 0, 5);
    set_hdr(2, 3, 4);
    set_hdr(3, 40, 40);
    set_hdr(4, 4, 4);
    set_hdr(7, 1, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checks++;
    assert (ready === 1'b1 && done === 1'b0 && err === 1'b0) else begin
      errs++; $error("FAIL rst_ctl: got r%b d%b e%b want r1 d0 e0",
                     ready, done, err);
    end
    checks++;
    assert (m_valid === 1'b0 && bram_en === 1'b0 &&
            meta_valid === 1'b0) else begin
      errs++; $error("FAIL rst_valid: got v%b en%b mv%b want 0",
                     m_valid, bram_en, meta_valid);
    end
    checks++;
    assert (rows === 8'd0 && cols === 8'd0 && matrix_name === 64'd0 &&
            m_data === 32'd0 && bram_addr === 14'd0) else begin
      errs++; $error("FAIL rst_data: got %0d %0d %h %h %0d want 0",
                     rows, cols, matrix_name, m_data, bram_addr);
    end

    read_matrix(2, 1'b0, 1'b0, 3, 4, 1'b0, -1);
    read_matrix(2, 1'b1, 1'b0, 3, 4, 1'b0, -1);

    sel = 1'b1;
    read_matrix(2, 1'b0, 1'b1, 3, 4, 1'b0, -1);
    read_matrix(2, 1'b1, 1'b1, 3, 4, 1'b0, -1);
    sel = 1'b0;

    read_matrix(1, 1'b0, 1'b0, 0, 5, 1'b1, -1);
    read_matrix(3, 1'b0, 1'b0, 40, 40, 1'b1, -1);

    read_matrix(4, 1'b0, 1'b0, 4, 4, 1'b0, 5);
    read_matrix(4, 1'b0, 1'b0, 4, 4, 1'b0, -1);

    read_matrix(7, 1'b0, 1'b0, 1, 1, 1'b0, -1);
    set_hdr(7, 33, 34);
    read_matrix(7, 1'b0, 1'b0, 33, 34, 1'b0, -1);

    @(negedge clk);
    start = 1'b1; matrix_id = 3'd2; col_major = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    assert (m_valid === 1'b0 && ready === 1'b1 && bram_en === 1'b0 &&
            rows === 8'd0 && meta_valid === 1'b0) else begin
      errs++; $error("FAIL mid_rst: got v%b r%b en%b rows%0d",
                     m_valid, ready, bram_en, rows);
    end
    rst = 1'b0;
    read_matrix(2, 1'b0, 1'b0, 3, 4, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
